// File: rtl/gerenciador_tiros.sv
// Shot scheduler: arbitrates player/enemy fire requests onto a pool of projectile slots and tracks each slot's life.
// Grant one cycle after an eligible request; requests are level and simply wait (no grant) while ineligible or paused.
module gerenciador_tiros #(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_ALIADO     = 1,
    parameter int MAX_INIMIGO    = 3,
    parameter int TICK_DIV       = 400000,
    parameter int INICIAR_HOLD   = 400000,
    parameter int COOLDOWN_TICKS = 25,
    parameter int TIMEOUT_TICKS  = 200
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    pausa,
    input  logic                    reiniciarJogo,
    input  logic                    req_aliado,
    input  logic                    req_inimigo,
    input  logic [9:0]              xi_aliado,
    input  logic [9:0]              yi_aliado,
    input  logic [9:0]              xi_inimigo,
    input  logic [9:0]              yi_inimigo,
    input  logic [NUM_SLOTS-1:0]    slot_bateu,
    output logic [NUM_SLOTS-1:0]    slot_iniciar,
    output logic [NUM_SLOTS-1:0]    slot_ehAliada,
    output logic [10*NUM_SLOTS-1:0] slot_xi,
    output logic [10*NUM_SLOTS-1:0] slot_yi,
    output logic [NUM_SLOTS-1:0]    slot_ocupado,
    output logic                    aceito_aliado,
    output logic                    aceito_inimigo,
    output logic                    tick
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(INICIAR_HOLD + 1);
    localparam int FW = $clog2(TIMEOUT_TICKS + 1);
    localparam int CW = $clog2(COOLDOWN_TICKS + 1);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {LIVRE, LANCANDO, VOANDO} estado_t;

    estado_t                 est_q  [NUM_SLOTS];
    estado_t                 est_d  [NUM_SLOTS];
    logic [HW-1:0]           hold_q [NUM_SLOTS];
    logic [HW-1:0]           hold_d [NUM_SLOTS];
    logic [FW-1:0]           voo_q  [NUM_SLOTS];
    logic [FW-1:0]           voo_d  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    pend_q, pend_d;
    logic [NUM_SLOTS-1:0]    bateu_prev_q;
    logic [NUM_SLOTS-1:0]    ehal_q, ehal_d;
    logic [10*NUM_SLOTS-1:0] xi_q, xi_d, yi_q, yi_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]           cool_q, cool_d;
    logic                    rr_ultimo_q, rr_ultimo_d;   // 1 = last grant went to the player
    logic                    aceito_al_q, aceito_in_q;

    logic [3:0]    n_al, n_in;
    logic          livre_any, tick_en;
    logic [IW-1:0] idx;
    logic          ok_al, ok_in, gnt_al, gnt_in;

    always_comb begin
        n_al      = '0;
        n_in      = '0;
        livre_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (est_q[k] != LIVRE) begin
                if (ehal_q[k]) n_al = n_al + 4'd1;
                else           n_in = n_in + 4'd1;
            end
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (est_q[k] == LIVRE) begin
                livre_any = 1'b1;
                idx       = IW'(k);
            end
        end
        tick_en = !pausa && !reiniciarJogo && (tick_cnt_q == TW'(TICK_DIV - 1));
        ok_al   = req_aliado && (cool_q == '0) && (n_al < 4'(MAX_ALIADO)) && livre_any
                  && !pausa && !reiniciarJogo;
        ok_in   = req_inimigo && (n_in < 4'(MAX_INIMIGO)) && livre_any
                  && !pausa && !reiniciarJogo;
        gnt_al  = ok_al && (!ok_in || !rr_ultimo_q);
        gnt_in  = ok_in && !gnt_al;
    end

    always_comb begin
        logic sobe;
        logic hit;
        ehal_d = ehal_q;
        xi_d   = xi_q;
        yi_d   = yi_q;
        pend_d = pend_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            est_d[k]  = est_q[k];
            hold_d[k] = hold_q[k];
            voo_d[k]  = voo_q[k];
            // bateu stays high until relaunch, so only a rising edge is an impact
            sobe = slot_bateu[k] & ~bateu_prev_q[k];
            hit  = pend_q[k] | sobe;
            if (reiniciarJogo) begin
                est_d[k]        = LIVRE;
                hold_d[k]       = '0;
                voo_d[k]        = '0;
                pend_d[k]       = 1'b0;
                ehal_d[k]       = 1'b0;
                xi_d[10*k +: 10] = '0;
                yi_d[10*k +: 10] = '0;
            end else begin
                case (est_q[k])
                    LANCANDO: begin
                        pend_d[k] = 1'b0;
                        if (!pausa) begin
                            if (hold_q[k] == HW'(INICIAR_HOLD - 1)) begin
                                est_d[k]  = VOANDO;
                                hold_d[k] = '0;
                            end else begin
                                hold_d[k] = hold_q[k] + HW'(1);
                            end
                        end
                    end
                    VOANDO: begin
                        pend_d[k] = hit;
                        if (!pausa) begin
                            if (hit) begin
                                est_d[k]  = LIVRE;
                                pend_d[k] = 1'b0;
                            end else if (tick_en) begin
                                if (voo_q[k] == FW'(TIMEOUT_TICKS - 1)) est_d[k] = LIVRE;
                                else voo_d[k] = voo_q[k] + FW'(1);
                            end
                        end
                    end
                    default: pend_d[k] = 1'b0;
                endcase
                if ((gnt_al || gnt_in) && (idx == IW'(k))) begin
                    est_d[k]         = LANCANDO;
                    hold_d[k]        = '0;
                    voo_d[k]         = '0;
                    pend_d[k]        = 1'b0;
                    ehal_d[k]        = gnt_al;
                    xi_d[10*k +: 10] = gnt_al ? xi_aliado : xi_inimigo;
                    yi_d[10*k +: 10] = gnt_al ? yi_aliado : yi_inimigo;
                end
            end
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (reiniciarJogo) tick_cnt_d = '0;
        else if (!pausa) tick_cnt_d = (tick_cnt_q == TW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TW'(1);

        cool_d = cool_q;
        if (reiniciarJogo)                  cool_d = '0;
        else if (gnt_al)                    cool_d = CW'(COOLDOWN_TICKS);
        else if (tick_en && cool_q != '0)   cool_d = cool_q - CW'(1);

        rr_ultimo_d = rr_ultimo_q;
        if (gnt_al)      rr_ultimo_d = 1'b1;
        else if (gnt_in) rr_ultimo_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                est_q[k]  <= LIVRE;
                hold_q[k] <= '0;
                voo_q[k]  <= '0;
            end
            pend_q       <= '0;
            bateu_prev_q <= '0;
            ehal_q       <= '0;
            xi_q         <= '0;
            yi_q         <= '0;
            tick_cnt_q   <= '0;
            cool_q       <= '0;
            rr_ultimo_q  <= 1'b0;
            aceito_al_q  <= 1'b0;
            aceito_in_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                est_q[k]  <= est_d[k];
                hold_q[k] <= hold_d[k];
                voo_q[k]  <= voo_d[k];
            end
            pend_q       <= pend_d;
            bateu_prev_q <= slot_bateu;
            ehal_q       <= ehal_d;
            xi_q         <= xi_d;
            yi_q         <= yi_d;
            tick_cnt_q   <= tick_cnt_d;
            cool_q       <= cool_d;
            rr_ultimo_q  <= rr_ultimo_d;
            aceito_al_q  <= gnt_al;
            aceito_in_q  <= gnt_in;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_iniciar[k] = (est_q[k] == LANCANDO);
            slot_ocupado[k] = (est_q[k] != LIVRE);
        end
    end

    assign slot_ehAliada  = ehal_q;
    assign slot_xi        = xi_q;
    assign slot_yi        = yi_q;
    assign aceito_aliado  = aceito_al_q;
    assign aceito_inimigo = aceito_in_q;
    assign tick           = tick_en;
endmodule

// File: tb/tb_gerenciador_tiros.sv
// Bench for gerenciador_tiros: directed stimulus pushes expected grants; a monitor pops and checks each aceito pulse.
module tb_gerenciador_tiros;
    localparam int N = 4;

    logic CLOCK_50 = 1'b0;
    logic reset, pausa, reiniciarJogo, req_aliado, req_inimigo;
    logic [9:0] xi_aliado, yi_aliado, xi_inimigo, yi_inimigo;
    logic [N-1:0] slot_bateu, slot_iniciar, slot_ehAliada, slot_ocupado;
    logic [10*N-1:0] slot_xi, slot_yi;
    logic aceito_aliado, aceito_inimigo, tick;

    typedef struct {
        bit aliado;
        int slot;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0] iniciar_prev = '0;

    always #5 CLOCK_50 = ~CLOCK_50;

    gerenciador_tiros #(
        .NUM_SLOTS(N), .MAX_ALIADO(1), .MAX_INIMIGO(3), .TICK_DIV(4),
        .INICIAR_HOLD(8), .COOLDOWN_TICKS(3), .TIMEOUT_TICKS(20)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
        .req_aliado(req_aliado), .req_inimigo(req_inimigo),
        .xi_aliado(xi_aliado), .yi_aliado(yi_aliado),
        .xi_inimigo(xi_inimigo), .yi_inimigo(yi_inimigo),
        .slot_bateu(slot_bateu), .slot_iniciar(slot_iniciar), .slot_ehAliada(slot_ehAliada),
        .slot_xi(slot_xi), .slot_yi(slot_yi), .slot_ocupado(slot_ocupado),
        .aceito_aliado(aceito_aliado), .aceito_inimigo(aceito_inimigo), .tick(tick)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic expect_grant(input bit al, input int s, input int x, input int y);
        exp_t e;
        e.aliado = al;
        e.slot   = s;
        e.x      = x;
        e.y      = y;
        exp_q.push_back(e);
    endtask

    // Monitor: every grant pulse must match the oldest outstanding expectation.
    always @(negedge CLOCK_50) begin
        exp_t e;
        logic [N-1:0] nova;
        nova = slot_iniciar & ~iniciar_prev;
        if (aceito_aliado || aceito_inimigo) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_grant: got aceito_aliado=%0d aceito_inimigo=%0d, expected no grant",
                         aceito_aliado, aceito_inimigo);
            end else begin
                e = exp_q.pop_front();
                chk("grant_kind", {aceito_aliado, aceito_inimigo}, {e.aliado, ~e.aliado});
                chk("grant_slot", nova, 64'(1) << e.slot);
                chk("grant_xi", slot_xi[10*e.slot +: 10], e.x);
                chk("grant_yi", slot_yi[10*e.slot +: 10], e.y);
                chk("grant_ehAliada", slot_ehAliada[e.slot], e.aliado);
            end
        end
        iniciar_prev = slot_iniciar;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        reset = 0; pausa = 0; reiniciarJogo = 0; req_aliado = 0; req_inimigo = 0;
        xi_aliado = 0; yi_aliado = 0; xi_inimigo = 0; yi_inimigo = 0; slot_bateu = '0;
        step(2);
        chk("rst_ocupado", slot_ocupado, 0);
        chk("rst_iniciar", slot_iniciar, 0);
        chk("rst_aceito", {aceito_aliado, aceito_inimigo}, 0);
        chk("rst_tick", tick, 0);
        chk("rst_xi", slot_xi, 0);
        reset = 1;
        step(1);

        // Player fire
        xi_aliado = 100; yi_aliado = 400; req_aliado = 1;
        expect_grant(1, 0, 100, 400);
        step(1);
        req_aliado = 0;
        chk("t1_iniciar", slot_iniciar, 4'b0001);
        chk("t1_ocupado", slot_ocupado, 4'b0001);
        chk("t1_xi0", slot_xi[9:0], 100);
        chk("t1_yi0", slot_yi[9:0], 400);
        n = 0;
        while (slot_iniciar[0] && n < 50) begin n++; step(1); end
        chk("t1_iniciar_cycles", n, 8);
        chk("t1_voando", slot_ocupado, 4'b0001);

        // Player limit while in flight (cooldown long expired), then impact
        step(16);
        req_aliado = 1;
        step(4);
        req_aliado = 0;
        chk("t2_limit_ocupado", slot_ocupado, 4'b0001);
        slot_bateu[0] = 1;
        step(1);
        chk("t2_impact_frees", slot_ocupado, 0);

        // Cooldown: grant on a tick cycle, free the slot, re-request; 3 ticks gate the regrant
        n = 0;
        while (!tick && n < 10) begin n++; step(1); end
        chk("t2_tick_seen", tick, 1);
        xi_aliado = 7; yi_aliado = 9; req_aliado = 1;
        expect_grant(1, 0, 7, 9);
        step(1);
        req_aliado = 0; slot_bateu[0] = 0;
        step(8);
        chk("t2_voando", {slot_iniciar[0], slot_ocupado[0]}, 2'b01);
        slot_bateu[0] = 1;
        step(1);
        chk("t2_impact2", slot_ocupado[0], 0);
        xi_aliado = 11; yi_aliado = 22; req_aliado = 1;
        expect_grant(1, 0, 11, 22);
        n = 0;
        do begin step(1); n++; end while (!aceito_aliado && n < 20);
        req_aliado = 0; slot_bateu[0] = 0;
        chk("t2_cooldown_latency", n, 4);

        // Async reset mid-launch
        reset = 0;
        #1;
        chk("arst_iniciar", slot_iniciar, 0);
        chk("arst_ocupado", slot_ocupado, 0);
        step(2);

        // Tie arbitration from reset
        req_aliado = 1; req_inimigo = 1;
        xi_aliado = 1; yi_aliado = 2; xi_inimigo = 300; yi_inimigo = 500;
        expect_grant(1, 0, 1, 2);
        expect_grant(0, 1, 300, 500);
        expect_grant(0, 2, 300, 500);
        expect_grant(0, 3, 300, 500);
        reset = 1;
        step(10);
        chk("t3_full", slot_ocupado, 4'b1111);
        chk("t3_ehAliada", slot_ehAliada, 4'b0001);
        chk("t3_all_granted", exp_q.size(), 0);
        req_aliado = 0; slot_bateu[0] = 1;
        n = 0;
        while (slot_iniciar[3] && n < 20) begin n++; step(1); end
        chk("t3_enemy_cap", slot_ocupado, 4'b1110);
        req_inimigo = 0;

        // Timeout of slot 3, counted from its first flying cycle
        n = 0; g = 0;
        while (slot_ocupado[3] && g < 400) begin
            if (tick) n++;
            g++;
            step(1);
        end
        chk("t4_timeout_ticks", n, 20);
        step(4);
        chk("t4_all_free", slot_ocupado, 0);

        // Pause during launch
        slot_bateu = '0;
        xi_inimigo = 55; yi_inimigo = 66; req_inimigo = 1;
        expect_grant(0, 0, 55, 66);
        step(1);
        req_inimigo = 0;
        n = 0; g = 0;
        for (int i = 1; i <= 19; i++) begin
            if (slot_iniciar[0]) n++;
            if (i >= 6 && i <= 15 && tick) g++;
            if (i == 16) chk("t5_grant_after_unpause", aceito_aliado, 1);
            if (i == 5) begin pausa = 1; xi_aliado = 8; yi_aliado = 9; req_aliado = 1; end
            if (i == 15) begin pausa = 0; expect_grant(1, 1, 8, 9); end
            if (i == 16) req_aliado = 0;
            step(1);
        end
        chk("t5_iniciar_cycles", n, 18);
        chk("t5_ticks_paused", g, 0);

        // Synchronous game restart with three busy slots
        xi_inimigo = 200; yi_inimigo = 201; req_inimigo = 1;
        expect_grant(0, 2, 200, 201);
        step(1);
        req_inimigo = 0;
        chk("t6_three_busy", slot_ocupado, 4'b0111);
        reiniciarJogo = 1;
        step(1);
        reiniciarJogo = 0;
        chk("t6_ocupado", slot_ocupado, 0);
        chk("t6_iniciar", slot_iniciar, 0);
        chk("t6_ehAliada", slot_ehAliada, 0);
        chk("t6_xi", slot_xi, 0);
        xi_aliado = 3; yi_aliado = 4; req_aliado = 1;
        expect_grant(1, 0, 3, 4);
        n = 0;
        do begin step(1); n++; end while (!aceito_aliado && n < 20);
        req_aliado = 0;
        chk("t6_cooldown_cleared", n, 1);
        reset = 0;
        #1;
        chk("t6_arst_iniciar", slot_iniciar, 0);
        chk("t6_arst_ocupado", slot_ocupado, 0);
        step(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
